fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction queue between the IFU and the decode stage. Buffers up to DEPTH
//  fetched {pc, instr} pairs. Valid/ready handshake on both sides. Synchronous
//  flush discards all queued entries on a taken branch or jump, so wrong-path
//  instructions never reach decode.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >= 2
//  AW      2   log2(DEPTH); pointer width
//  DW      32  instruction and PC width
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     synchronous, active-high; clears queue
//  flush      in   1     synchronous discard of all entries
//  in_valid   in   1     IFU presents in_instr/in_pc
//  in_ready   out  1     queue can accept; = !full
//  in_instr   in   DW    fetched instruction
//  in_pc      in   DW    PC of in_instr
//  out_valid  out  1     head entry valid; = !empty
//  out_ready  in   1     decode consumes head this cycle
//  out_instr  out  DW    head instruction; 32'h0 (nop) when empty
//  out_pc     out  DW    head PC; 32'h0 when empty
//  count      out  AW+1  number of occupied entries, 0..DEPTH
//  full       out  1     count == DEPTH
//  empty      out  1     count == 0
// BEHAVIOUR
//  - Reset: rd_ptr = wr_ptr = 0, count = 0, empty = 1, full = 0, in_ready = 1,
//    out_valid = 0, out_instr = out_pc = 0. Storage contents need no reset.
//  - Priority on each rising edge: reset > flush > push/pop.
//  - push = in_valid & in_ready: write mem[wr_ptr], then wr_ptr += 1 (mod DEPTH).
//  - pop = out_valid & out_ready: rd_ptr += 1 (mod DEPTH).
//  - count next = count + push - pop. Push and pop in the same cycle leave count
//    unchanged.
//  - in_ready depends only on state (!full). There is no combinational path from
//    out_ready, so a full queue does not accept a push even while popping.
//  - Head is combinational from registered state: out_instr/out_pc = mem[rd_ptr]
//    when count != 0, else 0.
//  - Latency: an entry pushed at edge N is visible at the head after edge N. There
//    is no bypass, so an empty queue shows out_valid = 0 during the push cycle.
//  - Order is strict FIFO. Each push is delivered exactly once.
//  - Flush: after the edge, count = 0 and rd_ptr = wr_ptr = 0. A push or pop
//    requested in the flush cycle is ignored (the dropped push is wrong-path).
//    in_ready stays 1 during the flush cycle; the IFU must treat that cycle's
//    data as discarded.
//  - Pointers wrap from DEPTH-1 to 0. Full and empty are decided by count, not by
//    pointer equality.
//  - out_ready while empty and in_valid while full have no effect. No error flag.
//  - Reset asserted mid-operation overrides flush, push and pop in that cycle.
// TESTING
//  1 reset: hold reset 2 cycles -> count=0, empty=1, in_ready=1, out_valid=0,
//    out_instr=0.
//  2 fill: out_ready=0, push PCs 0x3000,0x3004,0x3008,0x300C -> count=4, full=1,
//    in_ready=0; push of 0x3010 is refused; head pc=0x3000.
//  3 drain order: from test 2, out_ready=1 for 4 cycles -> out_pc sequence is
//    0x3000,0x3004,0x3008,0x300C; then empty=1, out_pc=0.
//  4 simultaneous: count=2, in_valid=1 and out_ready=1 for 6 cycles -> count stays
//    2, pointers wrap past 3, order preserved.
//  5 flush: count=3 with in_valid=1 (pc 0x3010) and flush=1 -> next cycle count=0,
//    out_valid=0; 0x3010 never appears at out_pc.
//  6 reset over flush: count=2, reset=1 with flush=1 and in_valid=1 -> count=0;
//    next push of pc 0x3000 appears at the head one cycle later.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between the IFU, the fetch queue and decode.
//   in_valid/in_ready/in_instr/in_pc     : IFU -> queue push side
//   out_valid/out_ready/out_instr/out_pc : queue -> decode pop side
// The master modport is the environment (IFU plus decode) and the slave modport is the queue.
interface fetch_queue_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_instr;
  logic [DW-1:0] in_pc;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [DW-1:0] out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between the IFU and the decode stage.
// The queue buffers up to DEPTH {pc, instr} pairs in strict FIFO order. A flush
// discards every queued entry, so wrong-path instructions never reach decode.
// Ports:
//   clk, reset  : rising-edge clock and synchronous active-high reset
//   flush       : synchronous discard of all entries. A push or pop in the same cycle is ignored.
//   bus (slave) : in_* push handshake and out_* pop handshake. The head is shown on out_instr/out_pc.
//   count       : number of occupied entries, 0..DEPTH
//   full, empty : count == DEPTH, count == 0
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  fetch_queue_if.slave      bus,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] instr_mem_r [DEPTH];
  logic [DW-1:0] pc_mem_r    [DEPTH];
  logic [AW-1:0] wr_ptr_r, wr_ptr_nxt_s;
  logic [AW-1:0] rd_ptr_r, rd_ptr_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic          full_r, full_nxt_s;
  logic          empty_r, empty_nxt_s;
  logic          push_s;
  logic          pop_s;

  // in_ready is derived from registered state only, so a full queue refuses a push even while it pops.
  assign push_s = bus.in_valid & ~full_r;
  assign pop_s  = bus.out_ready & ~empty_r;

  // Next-state logic. A flush zeroes the pointers and the count, and it drops any push or pop in that cycle.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      wr_ptr_nxt_s = {AW{1'b0}};
      rd_ptr_nxt_s = {AW{1'b0}};
      count_nxt_s  = {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_nxt_s = count_r - {{AW{1'b0}}, 1'b1};
        default: count_nxt_s = count_r;
      endcase
    end
    full_nxt_s  = (count_nxt_s == DEPTH_C);
    empty_nxt_s = (count_nxt_s == {(AW+1){1'b0}});
  end

  // State registers. Reset takes priority over the flush, push and pop already folded into the next-state values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= full_nxt_s;
      empty_r  <= empty_nxt_s;
    end
  end

  // Storage write. The contents are not reset because count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push_s & ~flush & ~reset) begin
      instr_mem_r[wr_ptr_r] <= bus.in_instr;
      pc_mem_r[wr_ptr_r]    <= bus.in_pc;
    end else begin
      instr_mem_r[wr_ptr_r] <= instr_mem_r[wr_ptr_r];
      pc_mem_r[wr_ptr_r]    <= pc_mem_r[wr_ptr_r];
    end
  end

  // Head view. There is no bypass. An empty queue shows a nop with PC 0.
  always_comb begin
    if (empty_r) begin
      bus.out_instr = {DW{1'b0}};
      bus.out_pc    = {DW{1'b0}};
    end else begin
      bus.out_instr = instr_mem_r[rd_ptr_r];
      bus.out_pc    = pc_mem_r[rd_ptr_r];
    end
  end

  assign bus.in_ready  = ~full_r;
  assign bus.out_valid = ~empty_r;
  assign count         = count_r;
  assign full          = full_r;
  assign empty         = empty_r;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// Each instruction word is pc ^ 32'hA5A5_0000, so out_instr can be checked against out_pc.
module tb_fetch_queue;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] count;
  logic       full;
  logic       empty;
  int         checks = 0;
  int         errors = 0;

  fetch_queue_if #(.DW(32)) bus ();

  fetch_queue #(.DEPTH(4), .AW(2), .DW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one clock. Inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic v, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = pc ^ 32'hA5A5_0000;
  endtask

  task automatic test_reset();
    drive_push(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", bus.out_instr); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h expected 0", bus.out_pc); end
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 32'h3000 + 32'(4 * i));
      if (i == 0) begin
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_no_bypass: got %b expected 0", bus.out_valid); end
      end
      tick();
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", count, i + 1); end
      checks++; if (bus.out_pc !== 32'h3000) begin errors++; $display("FAIL fill_head_pc: got %h expected 3000", bus.out_pc); end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); end
    drive_push(1'b1, 32'h3010);
    tick();
    drive_push(1'b0, 32'h0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_refused_count: got %0d expected 4", count); end
    checks++; if (bus.out_pc !== 32'h3000) begin errors++; $display("FAIL fill_refused_head: got %h expected 3000", bus.out_pc); end
    checks++; if (bus.out_instr !== (32'h3000 ^ 32'hA5A5_0000)) begin errors++; $display("FAIL fill_head_instr: got %h expected %h", bus.out_instr, 32'h3000 ^ 32'hA5A5_0000); end
  endtask

  task automatic test_drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_pc !== 32'h3000 + 32'(4 * i)) begin errors++; $display("FAIL drain_order: got %h expected %h", bus.out_pc, 32'h3000 + 32'(4 * i)); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL drain_out_pc: got %h expected 0", bus.out_pc); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_pop_empty_count: got %0d expected 0", count); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    bus.out_ready = 1'b0;
    drive_push(1'b1, 32'h4000); tick();
    drive_push(1'b1, 32'h4004); tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_setup_count: got %0d expected 2", count); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_push(1'b1, 32'h4008 + 32'(4 * i));
      #1;
      checks++; if (bus.out_pc !== 32'h4000 + 32'(4 * i)) begin errors++; $display("FAIL simul_order: got %h expected %h", bus.out_pc, 32'h4000 + 32'(4 * i)); end
      tick();
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL simul_count: got %0d expected 2", count); end
    end
    drive_push(1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.out_pc !== 32'h4018 + 32'(4 * i)) begin errors++; $display("FAIL simul_tail: got %h expected %h", bus.out_pc, 32'h4018 + 32'(4 * i)); end
      tick();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %b expected 1", empty); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      drive_push(1'b1, 32'h7000 + 32'(4 * i));
      tick();
    end
    drive_push(1'b1, 32'h7010);
    bus.out_ready = 1'b1;
    tick();
    drive_push(1'b0, 32'h0);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_count: got %0d expected 3", count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_pc !== 32'h7004 + 32'(4 * i)) begin errors++; $display("FAIL full_pop_order: got %h expected %h", bus.out_pc, 32'h7004 + 32'(4 * i)); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_pop_empty: got %b expected 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_push(1'b1, 32'h3000 + 32'(4 * i));
      tick();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_setup_count: got %0d expected 3", count); end
    drive_push(1'b1, 32'h3010);
    bus.out_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b expected 1", bus.in_ready); end
    tick();
    flush = 1'b0;
    drive_push(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL flush_out_pc: got %h expected 0", bus.out_pc); end
    drive_push(1'b1, 32'h5000);
    tick();
    drive_push(1'b0, 32'h0);
    checks++; if (bus.out_pc !== 32'h5000) begin errors++; $display("FAIL flush_next_head: got %h expected 5000", bus.out_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_next_count: got %0d expected 1", count); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drained: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_reset_over_flush();
    bus.out_ready = 1'b0;
    drive_push(1'b1, 32'h6000); tick();
    drive_push(1'b1, 32'h6004); tick();
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rof_setup_count: got %0d expected 2", count); end
    drive_push(1'b1, 32'h6008);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    drive_push(1'b0, 32'h0);
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rof_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rof_empty: got %b expected 1", empty); end
    drive_push(1'b1, 32'h3000);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rof_no_bypass: got %b expected 0", bus.out_valid); end
    tick();
    drive_push(1'b0, 32'h0);
    checks++; if (bus.out_pc !== 32'h3000) begin errors++; $display("FAIL rof_head_pc: got %h expected 3000", bus.out_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rof_head_count: got %0d expected 1", count); end
  endtask

  initial begin
    drive_push(1'b0, 32'h0);
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_full_pop();
    test_flush();
    test_reset_over_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
